// File: rtl/clock_divider.sv
// Divides clk by 2*N into a 50 % duty square wave, with a one-cycle strobe
// in the clk domain at every output edge.
module clock_divider #(
    parameter int unsigned N  = 50_000,
    parameter int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    localparam logic [CW-1:0] TERM = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_out_q;
    logic          clk_out_d;
    logic          tick_q;
    logic          tick_d;

    // Next-state: wrap at N-1, toggling the output and firing the strobe there.
    always_comb begin
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (cnt_q == TERM) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
        end else begin
            cnt_d     = cnt_q + CW'(1);
            clk_out_d = clk_out_q;
            tick_d    = 1'b0;
        end
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider at N = 4, 1, 5 and 16 sharing one clock and reset.
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic out4, tick4, out1, tick1, out5, tick5, out16, tick16;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned k = 0;
    logic [7:0] exp_q[$];

    clock_divider #(.N(4))  dut4  (.clk(clk), .rst(rst), .clk_out(out4),  .tick(tick4));
    clock_divider #(.N(1))  dut1  (.clk(clk), .rst(rst), .clk_out(out1),  .tick(tick1));
    clock_divider #(.N(5))  dut5  (.clk(clk), .rst(rst), .clk_out(out5),  .tick(tick5));
    clock_divider #(.N(16)) dut16 (.clk(clk), .rst(rst), .clk_out(out16), .tick(tick16));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Expected {clk_out, tick} after k clocked edges since reset release.
    function automatic logic [1:0] model(input int unsigned n, input int unsigned edges);
        logic o;
        logic t;
        o = ((edges / n) % 2) == 1;
        t = (edges >= n) && ((edges % n) == 0);
        return {o, t};
    endfunction

    // Scoreboard: push expectations at each edge, pop and compare just after it.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            if (rst) k = k + 1;
            else     k = 0;
            exp_q.push_back({model(16, k), model(5, k), model(1, k), model(4, k)});
            #1;
            e = exp_q.pop_front();
            check_eq("n4_clk_out",  {31'd0, out4},   {31'd0, e[1]});
            check_eq("n4_tick",     {31'd0, tick4},  {31'd0, e[0]});
            check_eq("n1_clk_out",  {31'd0, out1},   {31'd0, e[3]});
            check_eq("n1_tick",     {31'd0, tick1},  {31'd0, e[2]});
            check_eq("n5_clk_out",  {31'd0, out5},   {31'd0, e[5]});
            check_eq("n5_tick",     {31'd0, tick5},  {31'd0, e[4]});
            check_eq("n16_clk_out", {31'd0, out16},  {31'd0, e[7]});
            check_eq("n16_tick",    {31'd0, tick16}, {31'd0, e[6]});
            check_eq("n5_cnt_le4",  {31'd0, (dut5.cnt_q <= 3'd4)}, 32'd1);
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        // Six edges in, the N=4 instance is high with cnt = 2.
        repeat (6) @(negedge clk);
        check_eq("n4_high_before_rst", {31'd0, out4}, 32'd1);
        check_eq("n4_cnt_before_rst", {30'd0, dut4.cnt_q}, 32'd2);
        rst = 1'b0;
        #1;
        check_eq("n4_async_clk_out", {31'd0, out4}, 32'd0);
        check_eq("n4_async_tick",    {31'd0, tick4}, 32'd0);
        check_eq("n1_async_clk_out", {31'd0, out1}, 32'd0);
        check_eq("n1_async_tick",    {31'd0, tick1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (70) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
